// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared state enum, default region geometry and address helpers for the framebuffer writer
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } fb_state_e;

  localparam int unsigned IMAGE_1_W_DEF = 400;
  localparam int unsigned IMAGE_1_H_DEF = 400;
  localparam int unsigned IMAGE_2_W_DEF = 200;
  localparam int unsigned IMAGE_2_H_DEF = 200;
  localparam int unsigned ADDR_W_DEF    = 19;

  // Image-2 sits directly after image-1 in the framebuffer.
  function automatic int unsigned base_addr(input int unsigned img1_w, input int unsigned img1_h);
    return img1_w * img1_h;
  endfunction

  // Counter width for a dimension; a dimension of 1 still needs a 1-bit counter.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - raster-order column/row counter with enable, clear and last-pixel flag
module raster_counter
  import fb_pkg::*;
#(
  parameter int unsigned WIDTH  = IMAGE_2_W_DEF,
  parameter int unsigned HEIGHT = IMAGE_2_H_DEF,
  localparam int unsigned COL_W = cnt_w(WIDTH),
  localparam int unsigned ROW_W = cnt_w(HEIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             last_o
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             col_last, row_last;

  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);

  // Next position: clear wins over enable; the final pixel wraps back to (0,0)
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = col_last && row_last;

endmodule

// File: rtl/framebuffer_region_writer.sv
// rtl/framebuffer_region_writer.sv - streams raster pixels into the image-2 framebuffer region; FB_WRITER_OVERRUN_EN adds the sticky overrun flag
module framebuffer_region_writer
  import fb_pkg::*;
#(
  parameter int unsigned IMAGE_1_W = IMAGE_1_W_DEF,
  parameter int unsigned IMAGE_1_H = IMAGE_1_H_DEF,
  parameter int unsigned IMAGE_2_W = IMAGE_2_W_DEF,
  parameter int unsigned IMAGE_2_H = IMAGE_2_H_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  output logic              pix_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  // The region must fit: base_addr + IMAGE_2_W*IMAGE_2_H <= 2**ADDR_W.
  localparam int unsigned       BASE_INT = base_addr(IMAGE_1_W, IMAGE_1_H);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_INT);
  localparam int unsigned       COL_W    = cnt_w(IMAGE_2_W);
  localparam int unsigned       ROW_W    = cnt_w(IMAGE_2_H);

  fb_state_e         state_q;
  logic              pix_ready_q, busy_q, done_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;

  logic              accept, start_go, abort_go, last_pix;
  logic [COL_W-1:0]  cnt_col;
  logic [ROW_W-1:0]  cnt_row;
  logic              unused_pos;

  assign accept   = pix_valid && pix_ready_q;
  assign start_go = (state_q == IDLE) && start && !abort;
  assign abort_go = (state_q == WRITE) && abort;

  raster_counter #(
    .WIDTH  (IMAGE_2_W),
    .HEIGHT (IMAGE_2_H)
  ) u_raster (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (accept),
    .clr_i  (start_go || abort_go),
    .col_o  (cnt_col),
    .row_o  (cnt_row),
    .last_o (last_pix)
  );

  // Position is kept for display-side reuse; only the last-pixel flag steers this block.
  assign unused_pos = ^{cnt_col, cnt_row};

  // Frame FSM with registered ready/busy/done outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pix_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_go) begin
            state_q     <= WRITE;
            pix_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        WRITE: begin
          if (abort) begin
            state_q     <= IDLE;
            pix_ready_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (accept && last_pix) begin
            state_q     <= DONE;
            pix_ready_q <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          pix_ready_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Running write address: reload at frame start, clear on abort, step per accepted pixel
  always_comb begin
    addr_d = addr_q;
    if (start_go) begin
      addr_d = BASE;
    end else if (abort_go) begin
      addr_d = '0;
    end else if (accept) begin
      addr_d = addr_q + 1'b1;
    end
  end

  // Address counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Write port: one-cycle strobe per accepted pixel; address/data hold between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q <= accept;
      if (accept) begin
        mem_addr_q  <= addr_q;
        mem_wdata_q <= pix_data;
      end
    end
  end

`ifdef FB_WRITER_OVERRUN_EN
  logic overrun_q;

  // Sticky flag for pixels offered while not accepting; an accepted start clears it first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (start_go) begin
      overrun_q <= 1'b0;
    end else if (pix_valid && ((state_q == IDLE) || (state_q == DONE))) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  assign pix_ready = pix_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_framebuffer_region_writer.sv
// tb/tb_framebuffer_region_writer.sv - randomized self-checking bench for framebuffer_region_writer
module tb_framebuffer_region_writer;

  localparam int BASE = 160000;
  localparam int NPIX = 40000;

  typedef struct packed {
    logic [18:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = 8'd0;
  logic        pix_ready, mem_we, busy, done, overrun;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;

  int checks = 0;
  int errors = 0;

  wr_t got_q[$];
  wr_t exp_q[$];
  int          done_cnt = 0;
  logic [18:0] done_addr = '0;
  logic        done_we = 1'b0;
  logic        done_ready = 1'b1;
  logic        busy_after = 1'b1;
  bit          busy_pend = 1'b0;

  int frame_idx = 0;
  bit m_write = 1'b0;

  framebuffer_region_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) got_q.push_back({mem_addr, mem_wdata});
      if (busy_pend) begin
        busy_after <= busy;
        busy_pend  <= 1'b0;
      end
      if (done) begin
        done_cnt   <= done_cnt + 1;
        done_addr  <= mem_addr;
        done_we    <= mem_we;
        done_ready <= pix_ready;
        busy_pend  <= 1'b1;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_write = 1'b1;
    frame_idx = 0;
  endtask

  // Drives until n pixels are accepted; the model expects an accept whenever it is in a frame and valid is high.
  task automatic run_pixels(input int n, input int gap_pct, input bit stray_start);
    int acc = 0;
    int budget = 0;
    while (acc < n && budget < 4 * n + 100) begin
      pix_valid = ($urandom_range(99) >= gap_pct);
      pix_data  = (gap_pct == 0) ? 8'(frame_idx % 256) : 8'($urandom);
      start     = stray_start && ($urandom_range(49) == 0);
      @(negedge clk);
      checks++;
      if (pix_ready !== m_write) begin
        errors++;
        $display("FAIL ready_in_frame pix %0d got %b exp %b", frame_idx, pix_ready, m_write);
      end
      if (pix_valid && m_write) begin
        exp_q.push_back({19'(BASE + frame_idx), pix_data});
        frame_idx++;
        acc++;
        if (frame_idx == NPIX) m_write = 1'b0;
      end
      tick();
      budget++;
    end
    pix_valid = 1'b0;
    start = 1'b0;
    checks++;
    if (acc != n) begin
      errors++;
      $display("FAIL accept_budget got %0d exp %0d", acc, n);
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #12;
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL reset_pix_ready got %b exp 0", pix_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
    checks++; if (mem_addr !== 19'd0) begin errors++; $display("FAIL reset_mem_addr got %0d exp 0", mem_addr); end
    checks++; if (mem_wdata !== 8'd0) begin errors++; $display("FAIL reset_mem_wdata got %0d exp 0", mem_wdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_frame;
    int g0 = got_q.size();
    int d0 = done_cnt;
    exp_q.delete();
    start_frame();
    run_pixels(NPIX, 0, 1'b0);
    repeat (3) tick();
    checks++;
    if (got_q.size() - g0 != exp_q.size()) begin
      errors++;
      $display("FAIL full_write_count got %0d exp %0d", got_q.size() - g0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      checks++;
      if (got_q[g0 + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL full_write[%0d] got addr %0d data %0d exp addr %0d data %0d",
                 i, got_q[g0 + i].addr, got_q[g0 + i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL full_done_count got %0d exp 1", done_cnt - d0); end
    checks++; if (done_addr !== 19'd199999) begin errors++; $display("FAIL full_done_addr got %0d exp 199999", done_addr); end
    checks++; if (done_we !== 1'b1) begin errors++; $display("FAIL full_done_with_write got %b exp 1", done_we); end
    checks++; if (done_ready !== 1'b0) begin errors++; $display("FAIL full_ready_in_done got %b exp 0", done_ready); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL full_busy_after_done got %b exp 0", busy_after); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_gapped;
    int g0 = got_q.size();
    int d0 = done_cnt;
    exp_q.delete();
    start_frame();
    run_pixels(1000, 40, 1'b1);
    pix_valid = 1'b1;
    pix_data  = 8'($urandom);
    abort     = 1'b1;
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b1) begin errors++; $display("FAIL gap_ready_at_abort got %b exp 1", pix_ready); end
    exp_q.push_back({19'(BASE + frame_idx), pix_data});
    frame_idx++;
    tick();
    abort = 1'b0;
    pix_valid = 1'b0;
    m_write = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_busy_after_abort got %b exp 0", busy); end
    repeat (2) tick();
    checks++;
    if (got_q.size() - g0 != exp_q.size()) begin
      errors++;
      $display("FAIL gap_write_count got %0d exp %0d", got_q.size() - g0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      checks++;
      if (got_q[g0 + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL gap_write[%0d] got addr %0d data %0d exp addr %0d data %0d",
                 i, got_q[g0 + i].addr, got_q[g0 + i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    if (got_q.size() > g0 + 200) begin
      checks++;
      if (got_q[g0 + 200].addr !== 19'd160200) begin
        errors++;
        $display("FAIL gap_row_wrap_addr got %0d exp 160200", got_q[g0 + 200].addr);
      end
    end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL gap_no_done got %0d exp %0d", done_cnt, d0); end
  endtask

  task automatic test_abort;
    int g0 = got_q.size();
    int d0 = done_cnt;
    int g1;
    exp_q.delete();
    start_frame();
    run_pixels(500, 0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    m_write = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %b exp 0", pix_ready); end
    repeat (2) tick();
    checks++;
    if (got_q.size() - g0 != 500) begin errors++; $display("FAIL abort_write_count got %0d exp 500", got_q.size() - g0); end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      checks++;
      if (got_q[g0 + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL abort_write[%0d] got addr %0d exp addr %0d", i, got_q[g0 + i].addr, exp_q[i].addr);
      end
    end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_no_done got %0d exp %0d", done_cnt, d0); end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_idle_busy got %b exp 0", busy); end
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL abort_start_idle_ready got %b exp 0", pix_ready); end
    g1 = got_q.size();
    exp_q.delete();
    start_frame();
    run_pixels(3, 0, 1'b0);
    repeat (2) tick();
    checks++;
    if (got_q.size() != g1 + 3) begin
      errors++;
      $display("FAIL restart_write_count got %0d exp 3", got_q.size() - g1);
    end else if (got_q[g1].addr !== 19'd160000) begin
      errors++;
      $display("FAIL restart_first_addr got %0d exp 160000", got_q[g1].addr);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    m_write = 1'b0;
  endtask

  task automatic test_async_reset;
    int g0;
    exp_q.delete();
    start_frame();
    run_pixels(50, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL areset_mem_we got %b exp 0", mem_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b exp 0", busy); end
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL areset_ready got %b exp 0", pix_ready); end
    checks++; if (mem_addr !== 19'd0) begin errors++; $display("FAIL areset_mem_addr got %0d exp 0", mem_addr); end
    #1 rst_n = 1'b1;
    m_write = 1'b0;
    g0 = got_q.size();
    pix_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (pix_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL areset_idle cycle %0d got ready %b busy %b exp 0 0", i, pix_ready, busy);
      end
    end
    tick();
    pix_valid = 1'b0;
    tick();
    checks++; if (got_q.size() != g0) begin errors++; $display("FAIL areset_no_write got %0d exp 0", got_q.size() - g0); end
  endtask

  task automatic test_overrun;
    int g0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_after_reset got %b exp 0", overrun); end
    g0 = got_q.size();
`ifdef FB_WRITER_OVERRUN_EN
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", overrun); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL ovr_no_write got %b exp 0", mem_we); end
    repeat (3) tick();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
    start = 1'b1;
    pix_valid = 1'b1;
    tick();
    start = 1'b0;
    pix_valid = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear_on_start got %b exp 0", overrun); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovr_start_busy got %b exp 1", busy); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
`else
    pix_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_disabled cycle %0d got %b exp 0", i, overrun); end
    end
    pix_valid = 1'b0;
`endif
    tick();
    checks++; if (got_q.size() != g0) begin errors++; $display("FAIL ovr_idle_writes got %0d exp 0", got_q.size() - g0); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gapped();
    test_abort();
    test_async_reset();
    test_overrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
